// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave backed by a 32-bit word array, with independent
// read and write burst engines. ram_array is left unreset so that preloaded contents survive a reset.
module axi_slave_mem #(
    parameter int C_OFFSET_WIDTH = 16
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        S_AXI_AWID,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic [1:0]  S_AXI_AWLOCK,
    input  logic [3:0]  S_AXI_AWCACHE,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic [3:0]  S_AXI_AWQOS,
    input  logic        S_AXI_AWUSER,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WUSER,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic        S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BUSER,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic        S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic [1:0]  S_AXI_ARLOCK,
    input  logic [3:0]  S_AXI_ARCACHE,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic [3:0]  S_AXI_ARQOS,
    input  logic        S_AXI_ARUSER,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic        S_AXI_RID,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RUSER,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);
    localparam int AW = C_OFFSET_WIDTH - 2;
    localparam int DEPTH = 1 << AW;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    logic [31:0] ram_array [0:DEPTH-1];
    w_state_t w_state;
    r_state_t r_state;
    logic [AW-1:0] w_idx, r_idx, w_step, r_step, r_next;
    logic w_fixed, r_fixed;
    logic [7:0] r_cnt;
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
                         S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWUSER, S_AXI_WUSER,
                         S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK,
                         S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARUSER};
    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_BUSER = 1'b0;
    assign S_AXI_RRESP = 2'b00;
    assign S_AXI_RUSER = 1'b0;
    // FIXED bursts hold the index; INCR and WRAP both step by one word
    assign w_step = {{(AW-1){1'b0}}, ~w_fixed};
    assign r_step = {{(AW-1){1'b0}}, ~r_fixed};
    assign r_next = r_idx + r_step;

    always_ff @(posedge ACLK) begin
        if (S_AXI_WREADY && S_AXI_WVALID)
            for (int i = 0; i < 4; i++)
                if (S_AXI_WSTRB[i]) ram_array[w_idx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state       <= W_IDLE;
            w_idx         <= '0;
            w_fixed       <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    S_AXI_AWREADY <= 1'b1;
                    if (S_AXI_AWREADY && S_AXI_AWVALID) begin
                        S_AXI_BID     <= S_AXI_AWID;
                        w_idx         <= S_AXI_AWADDR[C_OFFSET_WIDTH-1:2];
                        w_fixed       <= (S_AXI_AWBURST == 2'b00);
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (S_AXI_WVALID) begin
                        w_idx <= w_idx + w_step;
                        if (S_AXI_WLAST) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state       <= R_IDLE;
            r_idx         <= '0;
            r_fixed       <= 1'b0;
            r_cnt         <= 8'd0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RID     <= 1'b0;
            S_AXI_RDATA   <= 32'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                        S_AXI_RID     <= S_AXI_ARID;
                        r_idx         <= S_AXI_ARADDR[C_OFFSET_WIDTH-1:2];
                        r_fixed       <= (S_AXI_ARBURST == 2'b00);
                        r_cnt         <= S_AXI_ARLEN;
                        S_AXI_RDATA   <= ram_array[S_AXI_ARADDR[C_OFFSET_WIDTH-1:2]];
                        S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_ARREADY <= 1'b0;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (S_AXI_RLAST) begin
                            S_AXI_RVALID  <= 1'b0;
                            S_AXI_RLAST   <= 1'b0;
                            S_AXI_ARREADY <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_idx       <= r_next;
                            S_AXI_RDATA <= ram_array[r_next];
                            r_cnt       <= r_cnt - 8'd1;
                            S_AXI_RLAST <= (r_cnt == 8'd1);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed and random AXI bursts checked against a word-array
// reference model of the memory.
module tb_axi_slave_mem;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        awid = 0, awvalid = 0, awready;
    logic [31:0] awaddr = 0;
    logic [7:0]  awlen = 0;
    logic [1:0]  awburst = 0;
    logic [31:0] wdata = 0;
    logic [3:0]  wstrb = 0;
    logic        wlast = 0, wvalid = 0, wready;
    logic        bid, buser, bvalid, bready = 0;
    logic [1:0]  bresp;
    logic        arid = 0, arvalid = 0, arready;
    logic [31:0] araddr = 0;
    logic [7:0]  arlen = 0;
    logic [1:0]  arburst = 0;
    logic        rid, rlast, ruser, rvalid, rready = 0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int errors = 0, checks = 0;
    logic [31:0] model [0:16383];
    logic [31:0] wd [0:255];
    logic [3:0]  ws [0:255];

    axi_slave_mem dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(3'd2),
        .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(2'd0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0),
        .S_AXI_AWQOS(4'd0), .S_AXI_AWUSER(1'b0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WUSER(1'b0),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BUSER(buser), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(3'd2),
        .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(2'd0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0),
        .S_AXI_ARQOS(4'd0), .S_AXI_ARUSER(1'b0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RUSER(ruser), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic aw_hs(input logic id, input logic [31:0] addr, input logic [1:0] burst, input logic [7:0] len);
        int n = 0;
        awid = id; awaddr = addr; awburst = burst; awlen = len; awvalid = 1;
        while (!awready && n < 50) begin tick(); n++; end
        chk("aw_ready", awready, 1);
        tick();
        awvalid = 0;
        chk("w_ready_after_aw", wready, 1);
    endtask

    task automatic ar_hs(input logic id, input logic [31:0] addr, input logic [1:0] burst, input logic [7:0] len);
        int n = 0;
        arid = id; araddr = addr; arburst = burst; arlen = len; arvalid = 1;
        while (!arready && n < 50) begin tick(); n++; end
        chk("ar_ready", arready, 1);
        tick();
        arvalid = 0;
        chk("r_valid_latency", rvalid, 1);
    endtask

    // Model: FIXED keeps the word, other bursts step one word modulo the array
    task automatic model_write(input logic [31:0] addr, input logic [1:0] burst, input int n);
        logic [13:0] idx = addr[15:2];
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 4; i++)
                if (ws[b][i]) model[idx][8*i +: 8] = wd[b][8*i +: 8];
            if (burst != 2'b00) idx = idx + 14'd1;
        end
    endtask

    task automatic axi_write(input logic id, input logic [31:0] addr, input logic [1:0] burst,
                             input logic [7:0] len, input int n, input bit gaps);
        int k;
        aw_hs(id, addr, burst, len);
        for (int b = 0; b < n; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin wvalid = 0; tick(); end
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == n - 1); wvalid = 1;
            k = 0;
            while (!wready && k < 50) begin tick(); k++; end
            chk("w_ready", wready, 1);
            tick();
        end
        wvalid = 0; wlast = 0;
        model_write(addr, burst, n);
        chk("b_valid", bvalid, 1);
        chk("b_id", bid, id);
        chk("b_resp", bresp, 0);
        k = $urandom_range(0, 2);
        for (int d = 0; d < k; d++) begin tick(); chk("b_valid_hold", bvalid, 1); end
        bready = 1;
        tick();
        bready = 0;
        chk("b_valid_drop", bvalid, 0);
        chk("aw_ready_back", awready, 1);
    endtask

    task automatic axi_read(input logic id, input logic [31:0] addr, input logic [1:0] burst,
                            input logic [7:0] len, input int mode);
        logic [13:0] idx = addr[15:2];
        int b = 0, cyc = 0;
        ar_hs(id, addr, burst, len);
        while (b <= int'(len) && cyc < 1200) begin
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            if (rvalid) begin
                chk("r_data", rdata, model[idx]);
                chk("r_id", rid, id);
                chk("r_last", rlast, (b == int'(len)));
                chk("r_resp", rresp, 0);
            end
            if (rvalid && rready) begin
                b++;
                if (burst != 2'b00) idx = idx + 14'd1;
            end
            tick();
            cyc++;
        end
        rready = 0;
        chk("r_beats", b, int'(len) + 1);
        chk("r_no_extra", rvalid, 0);
        chk("ar_ready_back", arready, 1);
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int b = 0; b < n; b++) begin wd[b] = base + b; ws[b] = 4'hF; end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] idx;
        int len;
        repeat (3) tick();
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_ids", {bid, rid}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_resp", {bresp, rresp, buser, ruser}, 0);
        ARESET = 0;
        tick();
        chk("post_rst_awready", awready, 1);
        chk("post_rst_arready", arready, 1);

        // ram_array[i] = i over the windows the later reads use
        for (int base = 0; base < 64; base += 16) begin
            fill(16, base);
            axi_write(0, base * 4, 2'b01, 15, 16, 0);
        end
        fill(16, 32'h2000);
        axi_write(1, 32'h8000, 2'b01, 15, 16, 1);
        axi_read(1, 32'h8000, 2'b01, 15, 0);

        fill(4, 32'hA0);
        axi_write(1, 32'h4000, 2'b01, 3, 4, 0);
        axi_read(0, 32'h4000, 2'b01, 3, 0);
        chk("wr_a3", dut.ram_array[14'h1003], 32'hA3);

        wd[0] = 32'h12345678; ws[0] = 4'hF;
        axi_write(0, 32'h50, 2'b01, 0, 1, 0);
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'b0011;
        axi_write(1, 32'h50, 2'b01, 0, 1, 0);
        chk("strobe_merge", dut.ram_array[20], 32'h1234FFFF);
        axi_read(1, 32'h50, 2'b00, 0, 0);

        axi_read(0, 32'h20, 2'b01, 3, 1);
        axi_read(1, 32'h0001_0004, 2'b01, 0, 0);
        chk("addr_wrap_word", model[1], 1);

        fill(3, 32'h5A5A0000); ws[1] = 4'b1000; ws[2] = 4'b0001;
        axi_write(0, 32'h3FFFC, 2'b10, 2, 3, 0);
        axi_read(0, 32'h3FFFC, 2'b01, 2, 2);
        fill(3, 32'h77000000); ws[0] = 4'b0110; ws[2] = 4'b1100;
        axi_write(1, 32'hC4, 2'b00, 2, 3, 1);
        axi_read(1, 32'hC4, 2'b00, 3, 1);
        fill(2, 32'hE0);
        axi_write(0, 32'h100, 2'b01, 7, 2, 0);
        fill(3, 32'hF0);
        axi_write(0, 32'h110, 2'b01, 0, 3, 0);
        axi_read(0, 32'h100, 2'b01, 6, 2);

        // Reset mid-burst on both channels, write still in its data phase
        aw_hs(1, 32'hA0, 2'b01, 3);
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF; wdata = wd[0]; wstrb = 4'hF; wlast = 0; wvalid = 1;
        tick();
        wvalid = 0;
        model_write(32'hA0, 2'b01, 1);
        ar_hs(0, 32'h28, 2'b01, 7);
        rready = 1;
        tick();
        ARESET = 1;
        #1;
        chk("abort_wready", wready, 0);
        chk("abort_rvalid", rvalid, 0);
        chk("abort_ready", {awready, arready}, 0);
        rready = 0;
        tick();
        ARESET = 0;
        tick();
        chk("abort_awready", awready, 1);
        chk("abort_arready", arready, 1);
        chk("keep_mem_a", dut.ram_array[40], 32'hCAFEF00D);
        chk("keep_mem_b", dut.ram_array[10], model[10]);
        axi_read(1, 32'hA0, 2'b01, 1, 0);

        // Reset while the write response is pending
        aw_hs(0, 32'hB0, 2'b01, 0);
        wd[0] = 32'h0BADBEEF; ws[0] = 4'b1110; wdata = wd[0]; wstrb = ws[0]; wlast = 1; wvalid = 1;
        tick();
        wvalid = 0; wlast = 0;
        model_write(32'hB0, 2'b01, 1);
        chk("pending_bvalid", bvalid, 1);
        ARESET = 1;
        #1;
        chk("abort_bvalid", bvalid, 0);
        tick();
        ARESET = 0;
        tick();
        chk("abort2_awready", awready, 1);
        axi_read(0, 32'hB0, 2'b01, 0, 0);

        for (int t = 0; t < 24; t++) begin
            idx = 14'($urandom_range(0, 47));
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b <= len; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
                axi_write(1'($urandom), {16'($urandom), idx, 2'($urandom)}, 2'($urandom_range(0, 2)),
                          8'($urandom), len + 1, 1);
            end else begin
                axi_read(1'($urandom), {16'($urandom), idx, 2'($urandom)}, 2'($urandom_range(0, 2)),
                         8'(len), $urandom_range(0, 2));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
